// File: rtl/fixed_adder.sv
// fixed_adder: registered sign-magnitude fixed-point adder/subtractor.
// Words are WIDTH bits: bit WIDTH-1 is the sign, bits WIDTH-2:0 are an
// unsigned magnitude (Q8.8 with the default parameters). One operation per
// clock, one-cycle latency, saturating on magnitude overflow.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous reset, active-high (clears sum and ovf)
//   a    - operand A, sign-magnitude
//   b    - operand B, sign-magnitude
//   sub  - 0: sum = a + b, 1: sum = a - b
//   sum  - registered result, sign-magnitude (never negative zero)
//   ovf  - registered; 1 when sum holds a saturated result
module fixed_adder #(
  parameter int unsigned WIDTH     = 17,
  parameter int unsigned FRAC_BITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

  localparam int unsigned MAG_W = WIDTH - 1;

  // The binary point position does not affect the arithmetic; only make sure
  // it fits inside the magnitude field.
  if (FRAC_BITS > MAG_W) begin : g_bad_frac
    $error("fixed_adder: FRAC_BITS exceeds magnitude width");
  end

  logic             sa;
  logic             sb_eff;
  logic [MAG_W-1:0] ma;
  logic [MAG_W-1:0] mb;
  logic [MAG_W:0]   add_full;
  logic [MAG_W-1:0] diff_ab;
  logic [MAG_W-1:0] diff_ba;

  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] sum_q;
  logic             ovf_d;
  logic             ovf_q;

  // Operand decode: subtraction is addition with B's sign flipped.
  always_comb begin
    sa       = a[WIDTH-1];
    sb_eff   = b[WIDTH-1] ^ sub;
    ma       = a[MAG_W-1:0];
    mb       = b[MAG_W-1:0];
    add_full = {1'b0, ma} + {1'b0, mb};
    diff_ab  = ma - mb;
    diff_ba  = mb - ma;
  end

  // Result select, saturation and zero-sign normalisation.
  always_comb begin
    logic             sign_r;
    logic [MAG_W-1:0] mag_r;
    sign_r = 1'b0;
    mag_r  = '0;
    ovf_d  = 1'b0;

    if (sa == sb_eff) begin
      sign_r = sa;
      if (add_full[MAG_W]) begin
        mag_r = '1;
        ovf_d = 1'b1;
      end else begin
        mag_r = add_full[MAG_W-1:0];
      end
    end else if (ma > mb) begin
      sign_r = sa;
      mag_r  = diff_ab;
    end else if (mb > ma) begin
      sign_r = sb_eff;
      mag_r  = diff_ba;
    end

    // A zero magnitude is always reported as +0.
    if (mag_r == '0) begin
      sign_r = 1'b0;
    end

    sum_d = {sign_r, mag_r};
  end

  // Single output register stage; reset wins over the sampled operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      ovf_q <= ovf_d;
    end
  end

  assign sum = sum_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_fixed_adder.sv
// Self-checking bench for fixed_adder: table-driven vectors applied
// back-to-back through a scoreboard queue, plus reset and random sequences.
module tb_fixed_adder;

  localparam int unsigned WIDTH = 17;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic [WIDTH-1:0] sum;
  logic             ovf;

  fixed_adder #(.WIDTH(WIDTH), .FRAC_BITS(8)) dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .sub (sub),
    .sum (sum),
    .ovf (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic [WIDTH-1:0] exp_sum;
    logic             exp_ovf;
    string            name;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] exp_sum;
    logic             exp_ovf;
    string            name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   n_pass = 0;
  int   n_chk  = 0;

  localparam logic [WIDTH-1:0] P6 = 17'h00600;
  localparam logic [WIDTH-1:0] N6 = 17'h10600;
  localparam logic [WIDTH-1:0] P4 = 17'h00400;
  localparam logic [WIDTH-1:0] N4 = 17'h10400;

  function automatic void add_vec(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                                  input logic vs, input logic [WIDTH-1:0] es,
                                  input logic eo, input string nm);
    vec_t v;
    v.a = va; v.b = vb; v.sub = vs; v.exp_sum = es; v.exp_ovf = eo; v.name = nm;
    vecs.push_back(v);
  endfunction

  // Independent reference: signed integer arithmetic, then clamp.
  function automatic void ref_model(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                                    input logic vs, output logic [WIDTH-1:0] es,
                                    output logic eo);
    int x, y, r, m;
    x = va[16] ? -int'(va[15:0]) : int'(va[15:0]);
    y = vb[16] ? -int'(vb[15:0]) : int'(vb[15:0]);
    r = vs ? x - y : x + y;
    m = (r < 0) ? -r : r;
    eo = 1'b0;
    if (m > 65535) begin
      m  = 65535;
      eo = 1'b1;
    end
    es = {(r < 0) && (m != 0), 16'(m)};
  endfunction

  // Drive one cycle of stimulus, push its expectation, compare after the edge.
  task automatic step(input logic r, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                      input logic vs, input logic [WIDTH-1:0] es, input logic eo,
                      input string nm);
    exp_t e;
    rst = r; a = va; b = vb; sub = vs;
    e.exp_sum = es; e.exp_ovf = eo; e.name = nm;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    n_chk++;
    if (sb_q.size() == 0) begin
      $display("FAIL %s: scoreboard empty, got sum=%05h ovf=%0b", nm, sum, ovf);
    end else begin
      e = sb_q.pop_front();
      if (sum === e.exp_sum && ovf === e.exp_ovf) begin
        n_pass++;
      end else begin
        $display("FAIL %s: got sum=%05h ovf=%0b, expected sum=%05h ovf=%0b",
                 e.name, sum, ovf, e.exp_sum, e.exp_ovf);
      end
    end
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb, es;
    logic             rs, eo;

    // Addition sign combinations
    add_vec(P6, P4, 1'b0, 17'h00A00, 1'b0, "add 6+4");
    add_vec(N6, P4, 1'b0, 17'h10200, 1'b0, "add -6+4");
    add_vec(P6, N4, 1'b0, 17'h00200, 1'b0, "add 6+-4");
    add_vec(N6, N4, 1'b0, 17'h10A00, 1'b0, "add -6+-4");
    add_vec(P4, N6, 1'b0, 17'h10200, 1'b0, "add 4+-6");
    add_vec(N4, P6, 1'b0, 17'h00200, 1'b0, "add -4+6");
    // Subtraction sign combinations
    add_vec(P6, P4, 1'b1, 17'h00200, 1'b0, "sub 6-4");
    add_vec(N6, P4, 1'b1, 17'h10A00, 1'b0, "sub -6-4");
    add_vec(P6, N4, 1'b1, 17'h00A00, 1'b0, "sub 6--4");
    add_vec(N6, N4, 1'b1, 17'h10200, 1'b0, "sub -6--4");
    add_vec(P4, P6, 1'b1, 17'h10200, 1'b0, "sub 4-6");
    add_vec(N4, N6, 1'b1, 17'h00200, 1'b0, "sub -4--6");
    // Zero results are always +0
    add_vec(P4, N4, 1'b0, 17'h00000, 1'b0, "zero 4+-4");
    add_vec(N4, P4, 1'b0, 17'h00000, 1'b0, "zero -4+4");
    add_vec(P4, P4, 1'b1, 17'h00000, 1'b0, "zero 4-4");
    add_vec(N4, N4, 1'b1, 17'h00000, 1'b0, "zero -4--4");
    add_vec(17'h10000, 17'h10000, 1'b0, 17'h00000, 1'b0, "zero -0+-0");
    add_vec(17'h10000, N4, 1'b0, N4, 1'b0, "-0+-4");
    add_vec(P4, P4, 1'b0, 17'h00800, 1'b0, "add 4+4");
    add_vec(N4, N4, 1'b0, 17'h10800, 1'b0, "add -4+-4");
    // Saturation, then recovery the next cycle
    add_vec(17'h08000, 17'h08000, 1'b0, 17'h0FFFF, 1'b1, "sat pos");
    add_vec(17'h1FFFF, 17'h00001, 1'b1, 17'h1FFFF, 1'b1, "sat neg");
    add_vec(P6, P4, 1'b0, 17'h00A00, 1'b0, "post-sat 6+4");
    add_vec(17'h0FFFF, 17'h00000, 1'b0, 17'h0FFFF, 1'b0, "max+0 no sat");

    // Reset held two edges with live operands, then release
    step(1'b1, P6, P4, 1'b0, 17'h00000, 1'b0, "reset edge 1");
    step(1'b1, P6, P4, 1'b0, 17'h00000, 1'b0, "reset edge 2");
    step(1'b0, P6, P4, 1'b0, 17'h00A00, 1'b0, "reset release");

    // Table applied on consecutive edges: no bubbles or repeats
    foreach (vecs[i]) begin
      step(1'b0, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].exp_sum,
           vecs[i].exp_ovf, vecs[i].name);
    end

    // Reset mid-stream over a saturating operation, then resume
    step(1'b1, 17'h08000, 17'h08000, 1'b0, 17'h00000, 1'b0, "mid reset");
    step(1'b0, N6, N4, 1'b0, 17'h10A00, 1'b0, "after mid reset");

    // Back-to-back random operands against the reference model
    for (int i = 0; i < 16; i++) begin
      ra = 17'($urandom);
      rb = 17'($urandom);
      if (i % 4 == 0) begin
        ra[15:14] = 2'b11;
        rb[15:14] = 2'b11;
      end
      rs = 1'($urandom);
      ref_model(ra, rb, rs, es, eo);
      step(1'b0, ra, rb, rs, es, eo, $sformatf("rand %0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
